hdlc_tx_framer: RTL and testbench

HDLC_TX_FRAMER -- requirements
Module: hdlc_tx_framer

---
 rtl/hdlc_pkg.sv | 24 ++
 rtl/hdlc_tx_framer_if.sv | 24 ++
 rtl/hdlc_crc16.sv | 21 ++
 rtl/hdlc_tx_framer.sv | 153 +++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: FSM state encoding, line patterns and the CRC-16 step
// used by both the transmit framer and a future receiver.
package hdlc_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_FLAG,
    ST_DATA,
    ST_FCS,
    ST_END_FLAG,
    ST_ABORT
  } hdlc_state_e;

  localparam logic [7:0]  FLAG       = 8'h7E;
  // Sent LSB first: one 0 followed by seven 1s.
  localparam logic [7:0]  ABORT_PAT  = 8'hFE;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [2:0]  ONES_LIMIT = 3'd5;

  // One bit of a non-reflected shift-left CRC in line order; sending the register
  // MSB first after the payload leaves a zero residue.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/hdlc_tx_framer_if.sv
// Payload-side handshake and serial-line signals of the HDLC transmit framer.
interface hdlc_tx_framer_if;
  logic       TxEN;
  logic [7:0] Tx_DataIn;
  logic       Tx_DataValid;
  logic       Tx_LastByte;
  logic       Tx_FCSen;
  logic       Tx_AbortFrame;
  logic       Tx_DataReady;
  logic       Tx;
  logic       Tx_ValidFrame;
  logic       Tx_Done;
  logic       Tx_AbortedTrans;

  modport master (
    output TxEN, Tx_DataIn, Tx_DataValid, Tx_LastByte, Tx_FCSen, Tx_AbortFrame,
    input  Tx_DataReady, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );

  modport slave (
    input  TxEN, Tx_DataIn, Tx_DataValid, Tx_LastByte, Tx_FCSen, Tx_AbortFrame,
    output Tx_DataReady, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
endinterface

// File: rtl/hdlc_crc16.sv
// Bit-serial CRC-16 (x^16+x^15+x^2+1), init zero; clear has priority over enable.
module hdlc_crc16
  import hdlc_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_crc
);
  logic [15:0] r_crc;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)        r_crc <= 16'h0000;
    else if (i_clr) r_crc <= 16'h0000;
    else if (i_en)  r_crc <= crc16_step(r_crc, i_bit);
  end

  assign o_crc = r_crc;
endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, LSB-first payload with zero insertion, optional
// CRC-16 FCS, abort sequence and enforced inter-frame idle time.
module hdlc_tx_framer
  import hdlc_pkg::*;
#(
  parameter int IDLE_BITS = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  hdlc_tx_framer_if.slave bus
);
  localparam int IW = $clog2(IDLE_BITS + 2);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_BITS);

  hdlc_state_e   r_state, w_next;
  logic [2:0]    r_bit_cnt;
  logic          r_fcs_hi;
  logic          r_b7_sent;
  logic [2:0]    r_ones;
  logic [7:0]    r_shift;
  logic          r_last;
  logic          r_fcsen;
  logic [IW-1:0] r_idle_cnt;
  logic          r_done;

  logic [15:0]   w_crc;
  logic [3:0]    w_fcs_idx;
  logic          w_abort_req;
  logic          w_stuff;
  logic          w_data_bit;
  logic          w_ones_hit;
  logic          w_unit_last;
  logic          w_byte_end;
  logic [2:0]    w_ones_nxt;

  assign w_abort_req = (r_state inside {ST_START_FLAG, ST_DATA, ST_FCS, ST_END_FLAG}) &&
                       (bus.Tx_AbortFrame || !bus.TxEN);
  assign w_stuff     = (r_state inside {ST_DATA, ST_FCS}) && (r_ones == ONES_LIMIT);
  // FCS register goes out MSB first, which is the low byte of the reflected value LSB first.
  assign w_fcs_idx   = ~{r_fcs_hi, r_bit_cnt};
  assign w_data_bit  = (r_state == ST_DATA) ? r_shift[r_bit_cnt] : w_crc[w_fcs_idx];
  assign w_ones_hit  = !w_stuff && w_data_bit && (r_ones == ONES_LIMIT - 3'd1);
  assign w_unit_last = (r_bit_cnt == 3'd7) && ((r_state == ST_DATA) || r_fcs_hi);
  // A byte whose final bit completes a run of five still owns the stuffed zero after it.
  assign w_byte_end  = w_stuff ? r_b7_sent : (w_unit_last && !w_ones_hit);
  assign w_ones_nxt  = (w_stuff || !w_data_bit) ? 3'd0 : r_ones + 3'd1;

  hdlc_crc16 u_crc (
    .Clk   (Clk),
    .Rst   (Rst),
    .i_clr ((r_state == ST_IDLE) || (r_state == ST_START_FLAG)),
    .i_en  ((r_state == ST_DATA) && !w_stuff),
    .i_bit (w_data_bit),
    .o_crc (w_crc)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:
        if (bus.TxEN && bus.Tx_DataValid && (r_idle_cnt >= IDLE_MAX)) w_next = ST_START_FLAG;
      ST_START_FLAG:
        if (w_abort_req)             w_next = ST_ABORT;
        else if (r_bit_cnt == 3'd7)  w_next = bus.Tx_DataValid ? ST_DATA : ST_ABORT;
      ST_DATA:
        if (w_abort_req)             w_next = ST_ABORT;
        else if (w_byte_end) begin
          if (r_last)                w_next = r_fcsen ? ST_FCS : ST_END_FLAG;
          else if (!bus.Tx_DataValid) w_next = ST_ABORT;
        end
      ST_FCS:
        if (w_abort_req)             w_next = ST_ABORT;
        else if (w_byte_end)         w_next = ST_END_FLAG;
      ST_END_FLAG:
        if (w_abort_req)             w_next = ST_ABORT;
        else if (r_bit_cnt == 3'd7)  w_next = ST_IDLE;
      ST_ABORT:
        if (r_bit_cnt == 3'd7)       w_next = ST_IDLE;
      default:                       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.Tx              = 1'b1;
    bus.Tx_DataReady    = 1'b0;
    bus.Tx_ValidFrame   = (r_state != ST_IDLE);
    bus.Tx_Done         = r_done;
    bus.Tx_AbortedTrans = (r_state == ST_ABORT) && (r_bit_cnt == 3'd0);
    case (r_state)
      ST_START_FLAG, ST_END_FLAG: bus.Tx = FLAG[r_bit_cnt];
      ST_DATA, ST_FCS:            bus.Tx = w_stuff ? 1'b0 : w_data_bit;
      ST_ABORT:                   bus.Tx = ABORT_PAT[r_bit_cnt];
      default:                    bus.Tx = 1'b1;
    endcase
    if (!w_abort_req)
      bus.Tx_DataReady = ((r_state == ST_START_FLAG) && (r_bit_cnt == 3'd7)) ||
                         ((r_state == ST_DATA) && w_byte_end && !r_last);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_bit_cnt  <= '0;
      r_fcs_hi   <= 1'b0;
      r_b7_sent  <= 1'b0;
      r_ones     <= '0;
      r_shift    <= '0;
      r_last     <= 1'b0;
      r_fcsen    <= 1'b0;
      r_idle_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == ST_END_FLAG) && (w_next == ST_IDLE);
      if (w_next != r_state) begin
        r_bit_cnt <= '0;
        r_fcs_hi  <= 1'b0;
        r_b7_sent <= 1'b0;
        // The run of ones carries from the last payload bit into the FCS.
        r_ones    <= (w_next == ST_FCS) ? w_ones_nxt : 3'd0;
        if (r_state == ST_IDLE)  r_fcsen    <= bus.Tx_FCSen;
        if (w_next == ST_IDLE)   r_idle_cnt <= '0;
        if (w_next == ST_DATA) begin
          r_shift <= bus.Tx_DataIn;
          r_last  <= bus.Tx_LastByte;
        end
      end else begin
        case (r_state)
          ST_IDLE:
            if (r_idle_cnt < IDLE_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;
          ST_START_FLAG, ST_END_FLAG, ST_ABORT:
            r_bit_cnt <= r_bit_cnt + 3'd1;
          ST_DATA, ST_FCS: begin
            r_ones <= w_ones_nxt;
            if (w_byte_end) begin
              r_bit_cnt <= '0;
              r_b7_sent <= 1'b0;
              r_shift   <= bus.Tx_DataIn;
              r_last    <= bus.Tx_LastByte;
            end else if (!w_stuff) begin
              if (w_unit_last) r_b7_sent <= 1'b1;
              else             {r_fcs_hi, r_bit_cnt} <= {r_fcs_hi, r_bit_cnt} + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: line bit strings, handshake counts, FCS residue,
// abort/underrun behaviour and asynchronous reset.
module tb_hdlc_tx_framer;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  hdlc_tx_framer_if bus();
  hdlc_tx_framer #(.IDLE_BITS(8)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  int    checks = 0;
  int    errors = 0;
  logic [7:0] pl [0:7];
  string obs;
  bit    txq[$];
  bit    ds[$];
  int    nready, ndone, naborted, ab_at, flen, gap, ones;
  bit    post_ok, seen;
  logic [7:0]  b;
  logic [15:0] c;
  logic        fb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_str(input string tag, input string got, input string exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s: got %s expected %s", tag, got, exp);
    end
  endtask

  // Drives one frame of n bytes from pl[], optionally dropping valid before byte
  // drop_at or pulsing abort in frame cycle abort_cyc, and records the line.
  task automatic send_frame(input int n, input bit fcs, input int drop_at, input int abort_cyc);
    int idx = 0;
    int cyc = 0;
    bit acc = 0;
    bit started = 0;
    bit fin = 0;
    obs = ""; txq.delete();
    nready = 0; ndone = 0; naborted = 0; ab_at = -1; post_ok = 1;
    bus.TxEN = 1; bus.Tx_FCSen = fcs; bus.Tx_DataIn = pl[0];
    bus.Tx_LastByte = (n == 1); bus.Tx_DataValid = 1; bus.Tx_AbortFrame = 0;
    for (int k = 0; k < 600 && !fin; k++) begin
      @(negedge Clk);
      if (bus.Tx_ValidFrame) begin
        started = 1;
        txq.push_back(bus.Tx);
        obs = $sformatf("%s%0d", obs, bus.Tx);
        if (bus.Tx_AbortedTrans) begin naborted++; ab_at = cyc; end
        if (bus.Tx_DataReady) begin nready++; acc = bus.Tx_DataValid; end
        cyc++;
      end else if (started) begin
        fin = 1;
        if (bus.Tx_Done) ndone++;
      end
      if (!fin) begin
        @(posedge Clk); #1;
        bus.Tx_AbortFrame = (cyc == abort_cyc);
        if (acc) begin
          acc = 0; idx++;
          if (idx >= n || idx == drop_at) bus.Tx_DataValid = 0;
          else begin bus.Tx_DataIn = pl[idx]; bus.Tx_LastByte = (idx == n - 1); end
        end
      end
    end
    flen = cyc;
    if (!fin) begin
      checks++; errors++;
      $error("FAIL frame_timeout: got no frame end expected end within 600 cycles");
    end
    bus.TxEN = 0; bus.Tx_DataValid = 0; bus.Tx_LastByte = 0; bus.Tx_AbortFrame = 0;
    repeat (3) begin
      @(negedge Clk);
      if (bus.Tx_Done) ndone++;
      if (!bus.Tx || bus.Tx_ValidFrame) post_ok = 0;
    end
  endtask

  initial begin
    bus.TxEN = 0; bus.Tx_DataIn = 8'h00; bus.Tx_DataValid = 0; bus.Tx_LastByte = 0;
    bus.Tx_FCSen = 0; bus.Tx_AbortFrame = 0;
    #3;
    chk("rst_tx", bus.Tx, 1);
    chk("rst_ready", bus.Tx_DataReady, 0);
    chk("rst_validframe", bus.Tx_ValidFrame, 0);
    chk("rst_done", bus.Tx_Done, 0);
    chk("rst_aborted", bus.Tx_AbortedTrans, 0);
    @(posedge Clk); @(posedge Clk); #1 Rst = 0;

    // Abort request while idle must do nothing.
    bus.Tx_AbortFrame = 1;
    seen = 0;
    @(posedge Clk); #1 bus.Tx_AbortFrame = 0;
    repeat (3) begin
      @(negedge Clk);
      if (bus.Tx_AbortedTrans || bus.Tx_ValidFrame || !bus.Tx) seen = 1;
    end
    chk("idle_abort_ignored", seen, 0);
    repeat (10) @(posedge Clk);
    #1;

    // 0x7E payload, no FCS: stuffed zero after five ones.
    pl[0] = 8'h7E;
    send_frame(1, 0, -1, -1);
    chk_str("seq_7e", obs, "0111111001111101001111110");
    chk("len_7e", flen, 25);
    chk("ready_7e", nready, 1);
    chk("done_7e", ndone, 1);
    chk("aborted_7e", naborted, 0);

    // 0xFF, 0x00: stuffing inside first byte, none across the boundary.
    pl[0] = 8'hFF; pl[1] = 8'h00;
    send_frame(2, 0, -1, -1);
    chk_str("seq_ff00", obs, "011111101111101110000000001111110");
    chk("ready_ff00", nready, 2);
    chk("done_ff00", ndone, 1);

    // 0x01,0x02,0x03 with FCS: destuff, recover payload and check zero residue.
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_frame(3, 1, -1, -1);
    ds.delete(); ones = 0;
    for (int i = 8; i < txq.size() - 8; i++) begin
      if (ones == 5) ones = 0;
      else begin
        ds.push_back(txq[i]);
        ones = txq[i] ? ones + 1 : 0;
      end
    end
    chk("fcs_destuffed_len", ds.size(), 40);
    for (int j = 0; j < 3; j++) begin
      for (int k = 0; k < 8; k++) b[k] = ds[j*8 + k];
      chk($sformatf("fcs_payload%0d", j), b, pl[j]);
    end
    c = 16'h0000;
    for (int i = 0; i < ds.size(); i++) begin
      fb = c[15] ^ ds[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    chk("fcs_residue", c, 16'h0000);
    chk("fcs_done", ndone, 1);
    chk("fcs_aborted", naborted, 0);

    // Abort pulse during bit 3 of the second byte (frame cycle 19).
    pl[0] = 8'h55; pl[1] = 8'hAA; pl[2] = 8'h33;
    send_frame(3, 0, -1, 19);
    chk_str("seq_abort", obs, "0111111010101010010101111111");
    chk("abort_pulses", naborted, 1);
    chk("abort_pulse_cycle", ab_at, 20);
    chk("abort_no_done", ndone, 0);
    chk("abort_line_idle_after", post_ok, 1);

    // Underrun: valid withdrawn before the second byte's handshake.
    pl[0] = 8'h11; pl[1] = 8'h22;
    send_frame(2, 0, 1, -1);
    chk_str("seq_underrun", obs, "011111101000100001111111");
    chk("underrun_ready", nready, 2);
    chk("underrun_aborted", naborted, 1);
    chk("underrun_no_done", ndone, 0);

    // Asynchronous reset in the middle of a zero payload byte.
    bus.TxEN = 1; bus.Tx_DataValid = 1; bus.Tx_DataIn = 8'h00; bus.Tx_LastByte = 0; bus.Tx_FCSen = 0;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge Clk);
      seen = bus.Tx_ValidFrame;
    end
    chk("rst_mid_frame_started", seen, 1);
    repeat (12) @(negedge Clk);
    @(posedge Clk); #2;
    chk("pre_reset_tx", bus.Tx, 0);
    Rst = 1; #1;
    chk("async_rst_tx", bus.Tx, 1);
    chk("async_rst_validframe", bus.Tx_ValidFrame, 0);
    chk("async_rst_ready", bus.Tx_DataReady, 0);
    chk("async_rst_done", bus.Tx_Done, 0);
    chk("async_rst_aborted", bus.Tx_AbortedTrans, 0);
    @(posedge Clk); @(posedge Clk); #1 Rst = 0;
    gap = 0; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge Clk);
      if (bus.Tx_ValidFrame) seen = 1;
      else gap++;
    end
    chk("post_reset_gap_ok", (gap >= 8 && gap <= 10), 1);
    Rst = 1; bus.TxEN = 0; bus.Tx_DataValid = 0;
    @(posedge Clk); #1 Rst = 0;
    repeat (2) @(posedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
